// File: rtl/ann_pkg.sv
// Shared constants for the ANN layer: weight RAM geometry and the
// weight sequencer's state encoding.
package ann_pkg;

  localparam int WEIGHT_DEPTH = 28;
  localparam int WEIGHT_AW    = 5;
  localparam int WEIGHT_DW    = 16;

  typedef logic [1:0] seq_state_t;

  localparam seq_state_t SEQ_IDLE  = 2'd0;
  localparam seq_state_t SEQ_LOAD  = 2'd1;
  localparam seq_state_t SEQ_READ  = 2'd2;
  localparam seq_state_t SEQ_DRAIN = 2'd3;

endpackage

// File: rtl/weight_bram_sequencer.sv
// Owns the weight RAM port: rewrites all weights from a loader stream, or
// streams all weights in address order to the MAC under ready/valid.
module weight_bram_sequencer
  import ann_pkg::*;
#(
  parameter int DEPTH = WEIGHT_DEPTH,
  parameter int AW    = WEIGHT_AW,
  parameter int DW    = WEIGHT_DW
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          RD_START,
  input  logic          LD_START,
  input  logic          L_VALID,
  output logic          L_READY,
  input  logic [DW-1:0] L_DATA,
  output logic          W_VALID,
  input  logic          W_READY,
  output logic [DW-1:0] W_DATA,
  output logic [AW-1:0] W_IDX,
  output logic          W_LAST,
  output logic [AW-1:0] RAM_ADDR,
  output logic [DW-1:0] RAM_DI,
  output logic          RAM_EN,
  output logic          RAM_WE,
  input  logic [DW-1:0] RAM_DO,
  output logic          BUSY,
  output logic          DONE
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  seq_state_t    r_state;
  seq_state_t    w_state_nxt;
  logic [AW-1:0] r_cnt;
  logic [AW-1:0] w_cnt_nxt;
  logic          r_w_valid;
  logic [AW-1:0] r_w_idx;
  logic          r_done;
  logic          w_done_nxt;

  logic          w_wr;
  logic          w_issue;
  logic          w_hs;
  logic          w_cnt_last;
  logic          w_w_last;

  assign w_cnt_last = (r_cnt == LAST_ADDR);
  assign w_wr       = (r_state == SEQ_LOAD) && L_VALID;
  // A read is only issued when the output slot frees this cycle, so RAM_DO
  // itself holds the stalled word and no skid buffer is needed.
  assign w_issue    = (r_state == SEQ_READ) && (!r_w_valid || W_READY);
  assign w_hs       = r_w_valid && W_READY;
  assign w_w_last   = r_w_valid && (r_w_idx == LAST_ADDR);

  assign RAM_EN   = w_wr || w_issue;
  assign RAM_WE   = w_wr;
  assign RAM_ADDR = (w_wr || w_issue) ? r_cnt : '0;
  assign RAM_DI   = w_wr ? L_DATA : '0;

  assign L_READY = (r_state == SEQ_LOAD);
  assign W_VALID = r_w_valid;
  assign W_DATA  = RAM_DO;
  assign W_IDX   = r_w_idx;
  assign W_LAST  = w_w_last;
  assign BUSY    = (r_state != SEQ_IDLE);
  assign DONE    = r_done;

  // NOTE: every output of this block gets a default first, so no path
  // through the case can leave a variable unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    case (r_state)
      SEQ_IDLE: begin
        if (LD_START) begin
          w_state_nxt = SEQ_LOAD;
          w_cnt_nxt   = '0;
        end else if (RD_START) begin
          w_state_nxt = SEQ_READ;
          w_cnt_nxt   = '0;
        end
      end
      SEQ_LOAD: begin
        if (w_wr) begin
          if (w_cnt_last) begin
            w_state_nxt = SEQ_IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + AW'(1);
          end
        end
      end
      SEQ_READ: begin
        if (w_issue) begin
          if (w_cnt_last) w_state_nxt = SEQ_DRAIN;
          else            w_cnt_nxt   = r_cnt + AW'(1);
        end
      end
      SEQ_DRAIN: begin
        if (w_hs && w_w_last) begin
          w_state_nxt = SEQ_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = SEQ_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= SEQ_IDLE;
      r_cnt     <= '0;
      r_w_valid <= 1'b0;
      r_w_idx   <= '0;
      r_done    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_done_nxt;
      if (w_issue) begin
        r_w_valid <= 1'b1;
        r_w_idx   <= r_cnt;
      end else if (w_hs) begin
        r_w_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_weight_bram_sequencer.sv
// Directed bench for weight_bram_sequencer with a falling-edge RAM model and
// a scoreboard of expected RAM writes and MAC handshakes.
module tb_weight_bram_sequencer;

  localparam int DEPTH = 28;
  localparam int AW    = 5;
  localparam int DW    = 16;

  typedef struct {
    logic [AW-1:0] idx;
    logic [DW-1:0] data;
  } exp_t;

  logic          CLK = 1'b0;
  logic          RST;
  logic          RD_START, LD_START;
  logic          L_VALID, L_READY;
  logic [DW-1:0] L_DATA;
  logic          W_VALID, W_READY;
  logic [DW-1:0] W_DATA;
  logic [AW-1:0] W_IDX;
  logic          W_LAST;
  logic [AW-1:0] RAM_ADDR;
  logic [DW-1:0] RAM_DI;
  logic          RAM_EN, RAM_WE;
  logic [DW-1:0] RAM_DO;
  logic          BUSY, DONE;

  weight_bram_sequencer dut (
    .CLK(CLK), .RST(RST), .RD_START(RD_START), .LD_START(LD_START),
    .L_VALID(L_VALID), .L_READY(L_READY), .L_DATA(L_DATA),
    .W_VALID(W_VALID), .W_READY(W_READY), .W_DATA(W_DATA), .W_IDX(W_IDX),
    .W_LAST(W_LAST), .RAM_ADDR(RAM_ADDR), .RAM_DI(RAM_DI), .RAM_EN(RAM_EN),
    .RAM_WE(RAM_WE), .RAM_DO(RAM_DO), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  // Weight RAM as the parent would instantiate it: updates on the falling edge.
  logic [DW-1:0] ram [0:31];
  logic [DW-1:0] ram_do_q = '0;
  assign RAM_DO = ram_do_q;
  always @(negedge CLK) begin
    if (RAM_EN) begin
      if (RAM_WE) ram[RAM_ADDR] <= RAM_DI;
      else        ram_do_q      <= ram[RAM_ADDR];
    end
  end

  logic [DW-1:0] exp_mem [0:DEPTH-1];
  exp_t          wr_q[$];
  exp_t          rd_q[$];
  int            n_pass  = 0;
  int            n_total = 0;
  int            cyc_n   = 0;
  int            hs_cnt;
  int            last_hs_cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
    cyc_n++;
  endtask

  // Sample mid-high phase: after inputs settle, before the RAM's falling edge.
  task automatic sample();
    exp_t e;
    #1;
    if (RAM_EN && RAM_WE) begin
      if (wr_q.size() == 0) chk("wr_unexpected", 32'(RAM_WE), 32'd0);
      else begin
        e = wr_q.pop_front();
        chk("wr_addr", 32'(RAM_ADDR), 32'(e.idx));
        chk("wr_data", 32'(RAM_DI), 32'(e.data));
      end
    end
    if (W_VALID && W_READY) begin
      if (rd_q.size() == 0) chk("rd_unexpected", 32'(W_VALID), 32'd0);
      else begin
        e = rd_q.pop_front();
        chk("rd_idx", 32'(W_IDX), 32'(e.idx));
        chk("rd_data", 32'(W_DATA), 32'(e.data));
        chk("rd_last", 32'(W_LAST), 32'(e.idx == AW'(DEPTH - 1)));
      end
      hs_cnt++;
      last_hs_cyc = cyc_n;
    end
  endtask

  // Full read stream; with bp set, stalls 3 cycles at W_IDX 5 then random ready.
  task automatic run_read(input bit bp);
    int            s_cyc;
    int            done_cyc;
    int            stall_left;
    bit            stalled;
    bit            prev_stall;
    logic [DW-1:0] prev_data;
    logic [AW-1:0] prev_idx;
    exp_t          e;
    hs_cnt      = 0;
    last_hs_cyc = -1;
    done_cyc    = -1;
    stall_left  = 0;
    stalled     = 1'b0;
    prev_stall  = 1'b0;
    prev_data   = '0;
    prev_idx    = '0;
    RD_START = 1'b1;
    W_READY  = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      e.idx  = AW'(i);
      e.data = exp_mem[i];
      rd_q.push_back(e);
    end
    s_cyc = cyc_n;
    sample();
    chk("rd_busy_start", 32'(BUSY), 32'd0);
    next_cycle();
    RD_START = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (bp) begin
        if (W_VALID && W_IDX == AW'(5) && !stalled) begin
          stall_left = 3;
          stalled    = 1'b1;
        end
        if (stall_left > 0) begin
          W_READY = 1'b0;
          stall_left--;
        end else begin
          W_READY = 1'($urandom_range(0, 1));
        end
      end
      sample();
      if (W_VALID && !W_READY) chk("stall_ram_en", 32'(RAM_EN), 32'd0);
      if (prev_stall) begin
        chk("stall_data", 32'(W_DATA), 32'(prev_data));
        chk("stall_idx", 32'(W_IDX), 32'(prev_idx));
      end
      prev_stall = W_VALID && !W_READY;
      prev_data  = W_DATA;
      prev_idx   = W_IDX;
      if (DONE) begin
        done_cyc = cyc_n;
        break;
      end
      next_cycle();
    end
    chk("rd_done_seen", 32'(DONE), 32'd1);
    chk("rd_busy_at_done", 32'(BUSY), 32'd0);
    chk("rd_hs_count", 32'(hs_cnt), 32'(DEPTH));
    chk("rd_q_empty", 32'(rd_q.size()), 32'd0);
    chk("rd_done_after_last", 32'(done_cyc - last_hs_cyc), 32'd1);
    if (!bp) begin
      chk("rd_last_hs_latency", 32'(last_hs_cyc - s_cyc), 32'(DEPTH + 1));
    end
    next_cycle();
    W_READY = 1'b0;
    sample();
    chk("rd_done_pulse", 32'(DONE), 32'd0);
    next_cycle();
  endtask

  initial begin
    exp_t e;
    int   found;
    for (int i = 0; i < 32; i++) ram[i] = 16'hDE00 + 16'(i);
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = 16'hDE00 + 16'(i);
    RST = 1'b1; RD_START = 1'b0; LD_START = 1'b0;
    L_VALID = 1'b0; L_DATA = '0; W_READY = 1'b0;

    next_cycle();
    next_cycle();
    sample();
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_done", 32'(DONE), 32'd0);
    chk("rst_l_ready", 32'(L_READY), 32'd0);
    chk("rst_w_valid", 32'(W_VALID), 32'd0);
    chk("rst_w_idx", 32'(W_IDX), 32'd0);
    chk("rst_ram", {RAM_EN, RAM_WE, 5'(RAM_ADDR), 16'(RAM_DI)}, 32'd0);

    // Idle gating: loader valid while idle must not write.
    RST     = 1'b0;
    L_VALID = 1'b1;
    L_DATA  = 16'hBEEF;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      sample();
      chk("idle_l_ready", 32'(L_READY), 32'd0);
      chk("idle_ram_en", 32'(RAM_EN), 32'd0);
    end

    // Simultaneous starts: load wins, read dropped.
    next_cycle();
    LD_START = 1'b1;
    RD_START = 1'b1;
    sample();
    chk("ld_start_ram_en", 32'(RAM_EN), 32'd0);
    next_cycle();
    LD_START = 1'b0;
    RD_START = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      L_DATA   = 16'h0100 + 16'(i);
      RD_START = (i == 3);
      e.idx    = AW'(i);
      e.data   = L_DATA;
      wr_q.push_back(e);
      exp_mem[i] = L_DATA;
      sample();
      chk("ld_busy", 32'(BUSY), 32'd1);
      chk("ld_l_ready", 32'(L_READY), 32'd1);
      chk("ld_ram_en", 32'(RAM_EN), 32'd1);
      next_cycle();
    end
    RD_START = 1'b0;
    L_DATA   = 16'hBEEF;
    sample();
    chk("ld_done", 32'(DONE), 32'd1);
    chk("ld_busy_at_done", 32'(BUSY), 32'd0);
    chk("ld_l_ready_after", 32'(L_READY), 32'd0);
    chk("ld_no_extra_write", 32'(RAM_EN), 32'd0);
    next_cycle();
    L_VALID = 1'b0;
    sample();
    chk("ld_done_pulse", 32'(DONE), 32'd0);
    chk("ld_read_dropped", 32'(BUSY), 32'd0);
    chk("ld_q_empty", 32'(wr_q.size()), 32'd0);
    next_cycle();

    // Streaming read at full rate, then with backpressure.
    run_read(1'b0);
    run_read(1'b1);

    // Reset mid-read at W_IDX 10, then a clean read from address 0.
    hs_cnt   = 0;
    RD_START = 1'b1;
    W_READY  = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      e.idx  = AW'(i);
      e.data = exp_mem[i];
      rd_q.push_back(e);
    end
    sample();
    next_cycle();
    RD_START = 1'b0;
    found    = 0;
    for (int k = 0; k < 60; k++) begin
      if (W_VALID && W_IDX == AW'(10)) begin
        found = 1;
        break;
      end
      sample();
      next_cycle();
    end
    chk("rst_mid_reached_idx10", 32'(found), 32'd1);
    RST = 1'b1;
    sample();
    next_cycle();
    RST = 1'b0;
    sample();
    chk("rst_mid_busy", 32'(BUSY), 32'd0);
    chk("rst_mid_w_valid", 32'(W_VALID), 32'd0);
    chk("rst_mid_ram_en", 32'(RAM_EN), 32'd0);
    chk("rst_mid_hs_before", 32'(hs_cnt), 32'd11);
    rd_q.delete();
    next_cycle();
    run_read(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
